// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the fetch stage: FSM state encoding,
// EBREAK encoding and the sequential PC step.
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;
  localparam int unsigned PC_INCR      = 4;

endpackage

// File: rtl/pc_fetch_if.sv
// Fetch-stage bus: instruction-memory request/response plus the IF/ID payload
// handed to decode. master = fetch stage, slave = memory/decode side.
interface pc_fetch_if #(
  parameter int ADDRESS_WIDTH = 32
);

  logic [ADDRESS_WIDTH-1:0] imem_addr;
  logic [ADDRESS_WIDTH-1:0] imem_instr;
  logic [ADDRESS_WIDTH-1:0] id_instr;
  logic [ADDRESS_WIDTH-1:0] id_pc;
  logic [ADDRESS_WIDTH-1:0] id_pc_plus4;
  logic                     id_valid;

  modport master (
    output imem_addr,
    input  imem_instr,
    output id_instr,
    output id_pc,
    output id_pc_plus4,
    output id_valid
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    input  id_instr,
    input  id_pc,
    input  id_pc_plus4,
    input  id_valid
  );

endinterface

// File: rtl/pc_fetch_if_id_reg.sv
// IF/ID pipeline register: one-cycle capture of the fetched word; flush beats
// stall (valid cleared, payload held), stall holds payload and valid.
module if_id_reg #(
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [ADDRESS_WIDTH-1:0] instr_d,
  input  logic [ADDRESS_WIDTH-1:0] pc_d,
  input  logic [ADDRESS_WIDTH-1:0] pc_plus4_d,
  output logic [ADDRESS_WIDTH-1:0] instr_q,
  output logic [ADDRESS_WIDTH-1:0] pc_q,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_q,
  output logic                     valid_q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q    <= '0;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (!stall) begin
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= 1'b1;
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// PC register and BOOT/RUN/HALT control for instruction fetch; one-cycle fetch
// latency, stall holds PC and IF/ID. Optional PC_FETCH_MISALIGN_CHECK_EN.
import pc_fetch_pkg::*;

module pc_fetch #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = ADDRESS_WIDTH'(32'h0000_0000)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     redirect,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  pc_fetch_if.master               bus,
  output logic                     halted,
  output logic                     misalign_err
);

  localparam logic [ADDRESS_WIDTH-1:0] INCR       = ADDRESS_WIDTH'(PC_INCR);
  localparam logic [ADDRESS_WIDTH-1:0] EBREAK     = ADDRESS_WIDTH'(EBREAK_INSTR);
  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ~ADDRESS_WIDTH'(3);

  fetch_state_t             state;
  logic [ADDRESS_WIDTH-1:0] pc;
  logic [ADDRESS_WIDTH-1:0] pc_plus4;
  logic                     redir_act;
  logic                     redir_bad;
  logic                     capture;
  logic                     ifid_flush;
  logic                     ifid_stall;

  assign pc_plus4  = pc + INCR;
  assign redir_act = redirect && (state != BOOT);

`ifdef PC_FETCH_MISALIGN_CHECK_EN
  logic err_q;

  assign redir_bad    = redir_act && (redirect_pc[1:0] != 2'b00);
  assign misalign_err = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (redir_bad) begin
      err_q <= 1'b1;
    end
  end
`else
  assign redir_bad    = 1'b0;
  assign misalign_err = 1'b0;
`endif

  // A capture happens only on a clean RUN cycle; everything else either holds
  // IF/ID (BOOT, stall) or invalidates it (redirect, flush, HALT).
  assign capture    = (state == RUN) && !redirect && !flush && !stall;
  assign ifid_flush = redir_act || ((state == RUN) && flush) || (state == HALT);
  assign ifid_stall = !capture;

  assign bus.imem_addr = pc;
  assign halted        = (state == HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
      pc    <= RESET_PC;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (redir_bad) begin
            state <= HALT;
          end else if (redirect) begin
            pc <= redirect_pc & ALIGN_MASK;
          end else if (!stall) begin
            pc <= pc_plus4;
            if (!flush && (bus.imem_instr == EBREAK)) begin
              state <= HALT;
            end
          end
        end
        HALT: begin
          if (redirect && !redir_bad) begin
            pc    <= redirect_pc & ALIGN_MASK;
            state <= RUN;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

  if_id_reg #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .stall      (ifid_stall),
    .flush      (ifid_flush),
    .instr_d    (bus.imem_instr),
    .pc_d       (pc),
    .pc_plus4_d (pc_plus4),
    .instr_q    (bus.id_instr),
    .pc_q       (bus.id_pc),
    .pc_plus4_q (bus.id_pc_plus4),
    .valid_q    (bus.id_valid)
  );

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: vector table for the sequential/stall/flush
// paths, hand sequences for EBREAK, wrap, misalignment and mid-run reset.
module tb_pc_fetch;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halted;
  logic        misalign_err;
  logic [31:0] mem [0:63];

  int n_checks = 0;
  int n_fail   = 0;

  pc_fetch_if #(.ADDRESS_WIDTH(32)) bus ();

  assign bus.imem_instr = mem[bus.imem_addr[7:2]];

  pc_fetch #(
    .ADDRESS_WIDTH (32),
    .RESET_PC      (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .bus          (bus),
    .halted       (halted),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] rpc;
    logic [31:0] exp_addr;
    logic [31:0] exp_id_pc;
    logic        exp_valid;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic f, input logic r, input logic [31:0] rpc);
    stall       = s;
    flush       = f;
    redirect    = r;
    redirect_pc = rpc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = NOP;

    //          stall flush redir rpc           addr          id_pc         valid
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h0000_0000, 32'h0,  1'b0}; // BOOT edge
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h0000_0004, 32'h0,  1'b1};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h0000_0008, 32'h4,  1'b1};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h0000_0008, 32'h4,  1'b1};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h0000_0008, 32'h4,  1'b1};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h0000_0008, 32'h4,  1'b1};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h0000_000C, 32'h8,  1'b1};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 32'h40, 32'h0000_0040, 32'h0,  1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h0000_0044, 32'h40, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,  32'h0000_0048, 32'h0,  1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 32'h0,  32'h0000_0048, 32'h0,  1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h0000_004C, 32'h48, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    check("reset imem_addr", bus.imem_addr, 32'h0);
    check("reset id_valid", {31'b0, bus.id_valid}, 32'h0);
    check("reset id_pc", bus.id_pc, 32'h0);
    check("reset halted", {31'b0, halted}, 32'h0);
    check("reset misalign_err", {31'b0, misalign_err}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].stall, vecs[i].flush, vecs[i].redirect, vecs[i].rpc);
      check($sformatf("vec%0d imem_addr", i), bus.imem_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d id_valid", i), {31'b0, bus.id_valid}, {31'b0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d id_pc", i), bus.id_pc, vecs[i].exp_id_pc);
        check($sformatf("vec%0d id_pc_plus4", i), bus.id_pc_plus4, vecs[i].exp_id_pc + 32'd4);
        check($sformatf("vec%0d id_instr", i), bus.id_instr, NOP);
      end
    end

    // EBREAK at 0x10 halts with PC frozen at 0x14; redirect resumes.
    mem[4] = EBREAK;
    step(1'b0, 1'b0, 1'b1, 32'h10);
    check("ebk redirect addr", bus.imem_addr, 32'h10);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("ebk id_instr", bus.id_instr, EBREAK);
    check("ebk id_valid", {31'b0, bus.id_valid}, 32'h1);
    check("ebk id_pc", bus.id_pc, 32'h10);
    check("ebk halted", {31'b0, halted}, 32'h1);
    check("ebk pc frozen", bus.imem_addr, 32'h14);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("halt id_valid drop", {31'b0, bus.id_valid}, 32'h0);
    check("halt pc held", bus.imem_addr, 32'h14);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("halt stays halted", {31'b0, halted}, 32'h1);
    check("halt pc held2", bus.imem_addr, 32'h14);
    step(1'b0, 1'b0, 1'b1, 32'h0);
    check("resume halted", {31'b0, halted}, 32'h0);
    check("resume addr", bus.imem_addr, 32'h0);
    check("resume id_valid", {31'b0, bus.id_valid}, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("resume fetch id_pc", bus.id_pc, 32'h0);
    check("resume fetch valid", {31'b0, bus.id_valid}, 32'h1);

    // PC wrap at the top of the address space.
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    check("wrap preset addr", bus.imem_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("wrap id_pc", bus.id_pc, 32'hFFFF_FFFC);
    check("wrap id_pc_plus4", bus.id_pc_plus4, 32'h0);
    check("wrap pc", bus.imem_addr, 32'h0);

    // Misaligned redirect target.
    step(1'b0, 1'b0, 1'b1, 32'h42);
`ifdef PC_FETCH_MISALIGN_CHECK_EN
    check("misalign err", {31'b0, misalign_err}, 32'h1);
    check("misalign halted", {31'b0, halted}, 32'h1);
    check("misalign pc untouched", bus.imem_addr, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("misalign err sticky", {31'b0, misalign_err}, 32'h1);
    step(1'b0, 1'b0, 1'b1, 32'h0);
    check("misalign resume", {31'b0, halted}, 32'h0);
    check("misalign err sticky2", {31'b0, misalign_err}, 32'h1);
`else
    check("misalign pc forced", bus.imem_addr, 32'h40);
    check("misalign err tied", {31'b0, misalign_err}, 32'h0);
    check("misalign not halted", {31'b0, halted}, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("misalign fetch id_pc", bus.id_pc, 32'h40);
    check("misalign next addr", bus.imem_addr, 32'h44);
`endif

    // Asynchronous reset while halted and stalled.
    step(1'b0, 1'b0, 1'b1, 32'h10);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("pre-rst halted", {31'b0, halted}, 32'h1);
    stall = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("async rst addr", bus.imem_addr, 32'h0);
    check("async rst id_instr", bus.id_instr, 32'h0);
    check("async rst id_pc", bus.id_pc, 32'h0);
    check("async rst id_pc_plus4", bus.id_pc_plus4, 32'h0);
    check("async rst id_valid", {31'b0, bus.id_valid}, 32'h0);
    check("async rst halted", {31'b0, halted}, 32'h0);
    check("async rst misalign", {31'b0, misalign_err}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b1, 32'h80);
    check("boot ignores redirect", bus.imem_addr, 32'h0);
    check("boot no capture", {31'b0, bus.id_valid}, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("post-rst id_pc", bus.id_pc, 32'h0);
    check("post-rst id_valid", {31'b0, bus.id_valid}, 32'h1);
    check("post-rst addr", bus.imem_addr, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32, giving the width of the PC, fetch address and instruction.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port stall  input  1  holds the PC and the IF/ID register.
REQ-006 SHALL have port flush  input  1  invalidates the IF/ID register.
REQ-007 SHALL have port redirect  input  1  loads redirect_pc (branch/jump taken).
REQ-008 SHALL have port redirect_pc  input  ADDRESS_WIDTH  redirect target.
REQ-009 SHALL have port imem_addr  output  ADDRESS_WIDTH  byte address to the instruction memory; equals the PC register.
REQ-010 SHALL have port imem_instr  input  ADDRESS_WIDTH  instruction word returned combinationally by memory for imem_addr.
REQ-011 SHALL have ports id_instr, id_pc, id_pc_plus4  output  ADDRESS_WIDTH  registered IF/ID payload.
REQ-012 SHALL have port id_valid  output  1  IF/ID payload is a live instruction.
REQ-013 SHALL have port halted  output  1  high while the FSM is in HALT.
REQ-014 SHALL have port misalign_err  output  1  sticky redirect-misalignment flag.

Function
REQ-015 SHALL implement FSM states BOOT, RUN, HALT; reset enters BOOT; BOOT -> RUN unconditionally on the next edge without capturing IF/ID.
REQ-016 In RUN with no stall/redirect/flush: IF/ID <= {imem_instr, pc, pc+4}, id_valid <= 1, pc <= pc+4 (one-cycle fetch latency).
REQ-017 pc+4 SHALL wrap modulo 2^ADDRESS_WIDTH (e.g. 32'hFFFF_FFFC -> 32'h0000_0000) with no flag.
REQ-018 stall SHALL hold pc and the entire IF/ID register, including id_valid, unchanged.
REQ-019 flush SHALL set id_valid <= 0; payload is don't-care; pc advances unless stall.
REQ-020 redirect SHALL override stall: pc <= redirect_pc, id_valid <= 0, in any state except BOOT.
REQ-021 Priority order SHALL be rst > redirect > flush > stall > normal advance; stall+flush gives id_valid <= 0 with pc held.
REQ-022 Capturing imem_instr == 32'h0010_0073 (EBREAK) in RUN SHALL latch it with id_valid=1, freeze pc at its address+4, and enter HALT.
REQ-023 In HALT, id_valid SHALL be 0 from the next edge onward; only redirect returns to RUN.
REQ-024 halted SHALL be asserted combinationally from state == HALT.

Reset
REQ-025 On rst: pc = RESET_PC, id_instr = 0, id_pc = 0, id_pc_plus4 = 0, id_valid = 0, misalign_err = 0, state = BOOT, immediately and independent of clk.
REQ-026 rst asserted mid-operation (including in HALT or during stall) SHALL discard all state with no completion of the in-flight fetch.

Configuration
REQ-027 With macro PC_FETCH_MISALIGN_CHECK_EN defined, redirect with redirect_pc[1:0] != 0 SHALL set misalign_err sticky until reset, load nothing into pc, and enter HALT.
REQ-028 Without PC_FETCH_MISALIGN_CHECK_EN, redirect_pc[1:0] SHALL be forced to 2'b00 on load and misalign_err SHALL be tied 0.

Structure
REQ-029 The shared package SHALL hold the FSM state enum (BOOT, RUN, HALT), the EBREAK encoding constant and the PC increment constant 4.
REQ-030 The IF/ID register SHALL be a sub-module if_id_reg (payload, valid, stall, flush); the PC/FSM logic stays in pc_fetch.

Verification
REQ-031 Reset release, RESET_PC=0, memory words 0x00000013 at 0,4,8 -> BOOT one cycle, then id_pc 0,4,8 on consecutive cycles with id_valid=1.
REQ-032 stall held 3 cycles at pc=8 -> imem_addr stays 8, id_pc stays 4, id_valid stays 1; release -> id_pc=8 next cycle.
REQ-033 Simultaneous redirect=1 (redirect_pc=0x40), stall=1, flush=1 -> next cycle pc=0x40, id_valid=0; following cycle id_pc=0x40.
REQ-034 Fetch 0x00100073 at 0x10 -> id_instr=0x00100073 with id_valid=1, halted=1, pc frozen at 0x14; redirect to 0x0 resumes RUN.
REQ-035 PC preset via redirect to 0xFFFFFFFC -> next id_pc_plus4=0x00000000 and pc=0x00000000.
REQ-036 With PC_FETCH_MISALIGN_CHECK_EN, redirect_pc=0x42 -> misalign_err=1 sticky, halted=1; without the macro -> pc=0x40, misalign_err=0.
